// File: rtl/bus_fabric.sv
// 6502 bus fabric: region decode, write gating, read-data mux, wait-state RDY and bank register.
// Define OPEN_BUS_EN to make unmapped reads return the last mapped read byte instead of 8'h00.
module bus_fabric #(
    parameter int unsigned        NREG     = 8,
    parameter logic [NREG*16-1:0] BASE     = {16'h8000, 16'h3200, 16'h4000, 16'h3000,
                                              16'h2000, 16'h0800, 16'h0400, 16'h0000},
    parameter logic [NREG*16-1:0] MASK     = {16'h8000, 16'hFF00, 16'hC000, 16'hFF00,
                                              16'hF000, 16'hFC00, 16'hFC00, 16'h7C00},
    parameter logic [NREG*4-1:0]  WAITS    = {4'd0, 4'd2, 4'd3, 4'd0, 4'd2, 4'd0, 4'd1, 4'd0},
    parameter logic [15:0]        BANK_ADR = 16'h3200,
    parameter int unsigned        BANK_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       AB,
    input  logic [7:0]        DO,
    input  logic              WE,
    output logic [7:0]        DI,
    output logic              RDY,
    output logic [NREG-1:0]   sel,
    output logic [NREG-1:0]   wr,
    input  logic [NREG*8-1:0] rd_data,
    output logic [BANK_W-1:0] bank
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [3:0]      hit_wait;
    logic            found;
    logic [NREG-1:0] sel_q;
    logic [7:0]      rd_mux;
    logic            unused_do;

    assign unused_do = ^DO;

    always_comb begin
        sel      = '0;
        hit_wait = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (!found && ((AB & MASK[16*i +: 16]) == BASE[16*i +: 16])) begin
                found    = 1'b1;
                sel[i]   = 1'b1;
                hit_wait = WAITS[4*i +: 4];
            end
        end
    end

    assign RDY = !reset || (state == ST_DONE) || ((state == ST_IDLE) && (hit_wait == 4'd0));
    assign wr  = (WE && RDY && reset) ? sel : '0;

    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (sel_q[i]) rd_mux = rd_mux | rd_data[8*i +: 8];
        end
    end

`ifdef OPEN_BUS_EN
    logic [7:0] ob_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      ob_q <= '0;
        else if (|sel_q) ob_q <= rd_mux;
    end

    assign DI = (|sel_q) ? rd_mux : ob_q;
`else
    assign DI = rd_mux;
`endif

    // The IDLE cycle that detects a waited access is itself the first stall cycle,
    // so WAIT lasts N-1 cycles and N=1 goes straight to DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sel_q <= '0;
            bank  <= '0;
        end else begin
            if (RDY) sel_q <= sel;
            if (WE && RDY && (AB == BANK_ADR)) bank <= DO[BANK_W-1:0];
            case (state)
                ST_IDLE: begin
                    if (hit_wait != 4'd0) begin
                        cnt   <= hit_wait - 4'd1;
                        state <= (hit_wait == 4'd1) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
